// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - MIPS instruction-fetch sequencer: PC, IF/ID capture, redirect, zero-run halt.
// Optional FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_sequencer #(
  parameter int RESET_PC  = 100,
  parameter int MEM_BYTES = 16384,
  parameter int NOP_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [1:0]  state,
  output logic        halted,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam int          ZW        = $clog2(NOP_LIMIT + 1);
  localparam logic [ZW-1:0] ZLAST   = ZW'(NOP_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        st;
  logic [31:0]   pc;
  logic [31:0]   pc_seq;
  logic [ZW-1:0] zcnt;

  assign imem_addr = pc;
  assign state     = st;
  assign pc_seq    = (pc + 32'd4) & ADDR_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      pc           <= 32'(RESET_PC);
      ifid_instr   <= 32'd0;
      ifid_pc4     <= 32'd0;
      ifid_valid   <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      zcnt         <= '0;
`ifdef FETCH_PERF_EN
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
`endif
    end else begin
      misalign_err <= 1'b0;
      case (st)
        RUN: begin
          if (redirect) begin
            pc           <= {redirect_pc[31:2], 2'b00} & ADDR_MASK;
            ifid_instr   <= 32'd0;
            ifid_pc4     <= 32'd0;
            ifid_valid   <= 1'b0;
            zcnt         <= '0;
            misalign_err <= |redirect_pc[1:0];
          end else if (stall) begin
`ifdef FETCH_PERF_EN
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
          end else begin
            pc <= pc_seq;
`ifdef FETCH_PERF_EN
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
`endif
            // The fetch that completes the zero run is dropped, not captured.
            if (imem_instr == 32'd0 && zcnt == ZLAST) begin
              st         <= HALT;
              halted     <= 1'b1;
              ifid_instr <= 32'd0;
              ifid_pc4   <= 32'd0;
              ifid_valid <= 1'b0;
            end else begin
              ifid_instr <= imem_instr;
              ifid_pc4   <= pc_seq;
              ifid_valid <= 1'b1;
              zcnt       <= (imem_instr == 32'd0) ? zcnt + ZW'(1) : '0;
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          // IDLE, and the unused encoding 3, wait for start with IF/ID bubbled.
          ifid_instr <= 32'd0;
          ifid_pc4   <= 32'd0;
          ifid_valid <= 1'b0;
          if (start) st <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a big-endian byte memory model.
module tb_fetch_sequencer;

  localparam int MEM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [1:0]  state;
  logic        halted;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [13:0] ia;
  logic [63:0] exp_q[$];

  fetch_sequencer #(.RESET_PC(100), .MEM_BYTES(MEM_BYTES), .NOP_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .state(state), .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign ia = imem_addr[13:0] & 14'h3FFC;
  assign imem_instr = {mem[ia], mem[ia + 14'd1], mem[ia + 14'd2], mem[ia + 14'd3]};

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input int a);
    exp_q.push_back({word_at(a), 32'((a + 4) & (MEM_BYTES - 1))});
  endtask

  // Monitor: every new IF/ID capture pops one expected {instr, pc4}.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc4 = 32'd0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (ifid_valid && (!prev_valid || ifid_pc4 != prev_pc4)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL capture_unexpected actual instr=0x%08h pc4=0x%08h required none", ifid_instr, ifid_pc4);
      end else begin
        e = exp_q.pop_front();
        if ({ifid_instr, ifid_pc4} !== e) begin
          errors++;
          $display("FAIL capture actual instr=0x%08h pc4=0x%08h required instr=0x%08h pc4=0x%08h",
                   ifid_instr, ifid_pc4, e[63:32], e[31:0]);
        end
      end
    end
    prev_valid = ifid_valid;
    prev_pc4   = ifid_pc4;
  end

  initial begin
    logic [31:0] frozen;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    put_word(100, 32'h48080000);
    put_word(104, 32'h48090004);
    put_word(108, 32'h480A0008);
    for (int a = 112; a <= 604; a += 4) put_word(a, 32'h20000000 | a);
    put_word(620, 32'h20000620);
    put_word(16380, 32'hDEADBEEF);
    put_word(0, 32'h12345678);

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", imem_addr, 32'd100);
    check("rst_state", 32'(state), 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    check("rst_pc4", ifid_pc4, 32'd0);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b0;

    tick();
    check("idle_hold_addr", imem_addr, 32'd100);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_state", 32'(state), 32'd1);
    check("run_first_addr", imem_addr, 32'd100);
    check("run_no_capture_yet", 32'(ifid_valid), 32'd0);

    for (int a = 100; a <= 108; a += 4) begin expect_fetch(a); tick(); end
    check("addr_after_3", imem_addr, 32'd112);
    check("instr_3rd", ifid_instr, 32'h480A0008);
    check("pc4_3rd", ifid_pc4, 32'd112);
`ifdef FETCH_PERF_EN
    check("perf_fetch_3", perf_fetch_cnt, 32'd3);
`endif

    for (int a = 112; a < 204; a += 4) begin expect_fetch(a); tick(); end
    check("addr_204", imem_addr, 32'd204);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'd204);
      check("stall_pc4", ifid_pc4, 32'd204);
      check("stall_valid", 32'(ifid_valid), 32'd1);
    end
`ifdef FETCH_PERF_EN
    check("perf_stall_3", perf_stall_cnt, 32'd3);
`endif
    stall = 1'b0;
    expect_fetch(204);
    tick();
    check("release_addr", imem_addr, 32'd208);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'd500;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("redir_addr", imem_addr, 32'd500);
    check("redir_valid", 32'(ifid_valid), 32'd0);
    check("redir_instr", ifid_instr, 32'd0);
    check("redir_misalign", 32'(misalign_err), 32'd0);
    expect_fetch(500);
    tick();

    redirect = 1'b1; redirect_pc = 32'h0000025A;
    tick();
    redirect = 1'b0;
    check("mis_addr", imem_addr, 32'd600);
    check("mis_pulse", 32'(misalign_err), 32'd1);
    expect_fetch(600);
    tick();
    check("mis_clear", 32'(misalign_err), 32'd0);

    redirect = 1'b1; redirect_pc = 32'd16380;
    tick();
    redirect = 1'b0;
    check("wrap_addr_top", imem_addr, 32'd16380);
    expect_fetch(16380);
    tick();
    check("wrap_pc4", ifid_pc4, 32'd0);
    check("wrap_addr", imem_addr, 32'd0);
    expect_fetch(0);
    tick();

    // Three zeros, one nonzero, then four zeros: only the second run halts.
    redirect = 1'b1; redirect_pc = 32'd608;
    tick();
    redirect = 1'b0;
    for (int a = 608; a <= 632; a += 4) begin expect_fetch(a); tick(); end
    check("pre_halt_state", 32'(state), 32'd1);
    check("pre_halt_halted", 32'(halted), 32'd0);
    tick();
    check("halt_state", 32'(state), 32'd2);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(ifid_valid), 32'd0);
    check("halt_instr", ifid_instr, 32'd0);
    frozen = imem_addr;

    start = 1'b1; redirect = 1'b1; redirect_pc = 32'd100; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_frozen_addr", imem_addr, frozen);
      check("halt_stays", 32'(state), 32'd2);
      check("halt_no_misalign", 32'(misalign_err), 32'd0);
      redirect_pc = 32'd102;
      stall = ~stall;
    end
    start = 1'b0; redirect = 1'b0; stall = 1'b0;

    reset = 1'b1;
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_addr", imem_addr, 32'd100);
    check("reset_halted", 32'(halted), 32'd0);
    tick();
    reset = 1'b0;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 5-stage MIPS pipeline.
- Owns the PC, drives the byte address into the combinational, big-endian, byte-addressed instruction memory, and captures the returned word into the IF/ID register.
- Sequences fetch: start-up, stall hold, branch/jump redirect with bubble insertion, and automatic halt when the program runs into zero-filled memory.

Parameters:
- RESET_PC, 100, byte address loaded into PC on reset; must be a multiple of 4.
- MEM_BYTES, 16384, instruction memory size in bytes; power of two, at least 4.
- NOP_LIMIT, 4, consecutive all-zero fetched words that trigger HALT; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- redirect  in  1  taken branch/jump resolved in ID.
- redirect_pc  in  32  target byte address for redirect.
- imem_addr  out  32  byte address to instruction memory; equals PC.
- imem_instr  in  32  word returned combinationally for imem_addr.
- ifid_instr  out  32  IF/ID instruction; 0 (nop) when bubbled.
- ifid_pc4  out  32  IF/ID PC+4 of the captured instruction.
- ifid_valid  out  1  IF/ID holds a real fetched instruction.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 HALT.
- halted  out  1  high while in HALT.
- misalign_err  out  1  one-cycle pulse when redirect_pc[1:0] is nonzero.

Behaviour:
- Reset, asynchronous: PC=RESET_PC, state=IDLE, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, misalign_err=0, zero counter=0.
- imem_addr = PC (combinational). The IF/ID capture of imem_instr is registered, so there is 1 cycle of latency from PC to ifid_instr.
- IDLE: PC frozen, IF/ID bubbled. start=1 moves to RUN on the next edge; the first capture occurs on the following edge.
- RUN, per edge, in priority order:
  1. redirect=1:
     - PC <= {redirect_pc[31:2],2'b00} & (MEM_BYTES-1).
     - IF/ID <= bubble (instr 0, pc4 0, valid 0).
     - zero counter <= 0.
     - misalign_err <= |redirect_pc[1:0].
     - Redirect wins over a simultaneous stall.
  2. else stall=1: PC, IF/ID and zero counter all hold; misalign_err <= 0.
  3. else normal fetch:
     - ifid_instr <= imem_instr, ifid_pc4 <= (PC+4) & (MEM_BYTES-1), ifid_valid <= 1.
     - PC <= (PC+4) & (MEM_BYTES-1). PC wraps MEM_BYTES-4 -> 0.
- Zero counter: only normal fetches update it.
  - imem_instr==0 increments it; if the counter already equals NOP_LIMIT-1, state <= HALT instead.
  - Any nonzero word clears it.
- HALT:
  - PC frozen, IF/ID forced to bubble on the entering edge and held there, halted=1.
  - stall, redirect and start are ignored. Only reset exits HALT.
- state encoding 3 is unreachable; if ever decoded, the block behaves as IDLE.
- misalign_err is 0 on every edge that does not take a redirect.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds ports:
  - perf_fetch_cnt (out, 32): counts normal fetches.
  - perf_stall_cnt (out, 32): counts RUN edges where stall=1 and redirect=0.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=100, then start pulse. Words at 100/104/108 are 0x48080000/0x48090004/0x480A0008 -> ifid_instr follows in that order on consecutive edges, ifid_pc4=104/108/112, ifid_valid=1, imem_addr=112 after the 3rd capture.
- Stall for 3 cycles while PC=204 -> PC stays 204 and IF/ID holds; with FETCH_PERF_EN, perf_stall_cnt=3. On release, the word at 204 is captured with ifid_pc4=208.
- Redirect and stall together, redirect_pc=500 -> next edge PC=500, ifid_valid=0, ifid_instr=0. Next edge captures the word at 500 with ifid_pc4=504.
- redirect_pc=0x0000025A -> PC=600 (0x258), misalign_err high for exactly one cycle.
- Start at PC=16380 with a nonzero word there -> ifid_pc4=0 and imem_addr=0 on the next cycle (wrap).
- Four consecutive zero words after PC=620 with NOP_LIMIT=4 -> after the 4th zero fetch, state=2 and halted=1. PC stays frozen despite start/redirect until reset, which returns state=0 and PC=100.
